// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - layer codes and sequencer state encodings shared by the CNN layer scheduler
package layer_sequencer_pkg;

    localparam logic [3:0] NOLAYER = 4'h0;
    localparam logic [3:0] LAYER0  = 4'h1;
    localparam logic [3:0] LAYER1  = 4'h2;
    localparam logic [3:0] LAYER2  = 4'h3;
    localparam logic [3:0] LAYER3  = 4'h4;
    localparam logic [3:0] AFFINE  = 4'h5;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_SETUP   = 3'd1,
        SEQ_CONV    = 3'd2,
        SEQ_BIAS    = 3'd3,
        SEQ_CAPTURE = 3'd4,
        SEQ_DONE    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - host/engine/bias-stage signal bundle for the layer sequencer
interface layer_sequencer_if;

    logic       start;
    logic       abort;
    logic       conv_done;
    logic [3:0] cs_layer;
    logic       conv_start;
    logic       bias_load;
    logic       layer_valid;
    logic [2:0] layer_idx;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, abort, conv_done,
        input  cs_layer, conv_start, bias_load, layer_valid, layer_idx, busy, done, err
    );

    modport slave (
        input  start, abort, conv_done,
        output cs_layer, conv_start, bias_load, layer_valid, layer_idx, busy, done, err
    );

endinterface

// File: rtl/layer_sequencer_seq_watchdog.sv
// rtl/layer_sequencer_seq_watchdog.sv - CONV-state cycle counter flagging an unresponsive engine
module layer_sequencer_seq_watchdog #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] r_count;

    // Held at zero outside CONV, so the entry cycle of CONV always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'd0;
        end else if (!i_enable) begin
            r_count <= 16'd0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - steps LAYER0..AFFINE through setup/conv/bias/capture; LAYER_SEQ_WATCHDOG_EN adds a CONV timeout
import layer_sequencer_pkg::*;

module layer_sequencer #(
    parameter int NUM_LAYERS  = 5,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    layer_sequencer_if.slave  bus
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_LAYERS - 1);

    seq_state_t  r_state;
    logic [3:0]  r_cs_layer;
    logic [2:0]  r_layer_idx;
    logic [7:0]  r_setup_cnt;
    logic        r_conv_start;
    logic        r_bias_load;
    logic        r_layer_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [2:0]  w_next_idx;
    logic [3:0]  w_next_code;
    logic        w_in_conv;
    logic        w_timeout;

    assign w_next_idx = r_layer_idx + 3'd1;
    assign w_in_conv  = (r_state == SEQ_CONV);

    always_comb begin
        w_next_code = NOLAYER;
        case (w_next_idx)
            3'd0:    w_next_code = LAYER0;
            3'd1:    w_next_code = LAYER1;
            3'd2:    w_next_code = LAYER2;
            3'd3:    w_next_code = LAYER3;
            3'd4:    w_next_code = AFFINE;
            default: w_next_code = NOLAYER;
        endcase
    end

`ifdef LAYER_SEQ_WATCHDOG_EN
    layer_sequencer_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_seq_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (w_in_conv),
        .o_expired (w_timeout)
    );
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SEQ_IDLE;
            r_cs_layer    <= NOLAYER;
            r_layer_idx   <= 3'd0;
            r_setup_cnt   <= 8'd0;
            r_conv_start  <= 1'b0;
            r_bias_load   <= 1'b0;
            r_layer_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_conv_start  <= 1'b0;
            r_bias_load   <= 1'b0;
            r_layer_valid <= 1'b0;
            r_done        <= 1'b0;
            if (bus.abort) begin
                r_state     <= SEQ_IDLE;
                r_cs_layer  <= NOLAYER;
                r_layer_idx <= 3'd0;
                r_setup_cnt <= 8'd0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    SEQ_IDLE: begin
                        if (bus.start) begin
                            r_state     <= SEQ_SETUP;
                            r_cs_layer  <= LAYER0;
                            r_layer_idx <= 3'd0;
                            r_setup_cnt <= 8'd0;
                            r_busy      <= 1'b1;
                            r_err       <= 1'b0;
                        end
                    end
                    SEQ_SETUP: begin
                        if (r_setup_cnt == SETUP_LAST) begin
                            r_state      <= SEQ_CONV;
                            r_conv_start <= 1'b1;
                        end else begin
                            r_setup_cnt <= r_setup_cnt + 8'd1;
                        end
                    end
                    SEQ_CONV: begin
                        // r_conv_start is high only on the entry cycle, masking a stale conv_done.
                        if (bus.conv_done && !r_conv_start) begin
                            r_state     <= SEQ_BIAS;
                            r_bias_load <= 1'b1;
                        end else if (w_timeout) begin
                            r_state     <= SEQ_IDLE;
                            r_cs_layer  <= NOLAYER;
                            r_layer_idx <= 3'd0;
                            r_busy      <= 1'b0;
                            r_err       <= 1'b1;
                        end
                    end
                    SEQ_BIAS: begin
                        r_state       <= SEQ_CAPTURE;
                        r_layer_valid <= 1'b1;
                    end
                    SEQ_CAPTURE: begin
                        if (r_layer_idx < LAST_IDX) begin
                            r_state     <= SEQ_SETUP;
                            r_layer_idx <= w_next_idx;
                            r_cs_layer  <= w_next_code;
                            r_setup_cnt <= 8'd0;
                        end else begin
                            r_state    <= SEQ_DONE;
                            r_done     <= 1'b1;
                            r_cs_layer <= NOLAYER;
                        end
                    end
                    SEQ_DONE: begin
                        r_state     <= SEQ_IDLE;
                        r_layer_idx <= 3'd0;
                        r_busy      <= 1'b0;
                    end
                    default: begin
                        r_state     <= SEQ_IDLE;
                        r_cs_layer  <= NOLAYER;
                        r_layer_idx <= 3'd0;
                        r_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cs_layer    = r_cs_layer;
    assign bus.conv_start  = r_conv_start;
    assign bus.bias_load   = r_bias_load;
    assign bus.layer_valid = r_layer_valid;
    assign bus.layer_idx   = r_layer_idx;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized pass schedules checked cycle by cycle against an arithmetic timeline model
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 65535;
`endif
    localparam int MAXT = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    layer_sequencer_if bus();

    layer_sequencer #(
        .NUM_LAYERS  (5),
        .SETUP_CYC   (2),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] codes [5] = '{LAYER0, LAYER1, LAYER2, LAYER3, AFFINE};

    logic [3:0] e_cs     [MAXT];
    int         e_idx    [MAXT];
    bit         e_cstart [MAXT];
    bit         e_bias   [MAXT];
    bit         e_valid  [MAXT];
    bit         e_busy   [MAXT];
    bit         e_done   [MAXT];
    bit         e_err    [MAXT];
    bit         d_start  [MAXT];
    bit         d_abort  [MAXT];
    bit         d_done   [MAXT];
    bit         conv_late[MAXT];
    int  plen;
    bit  model_err = 1'b0;
    int  start_t, c2_t, lat2, bias_t[5];
    int  obs_cs_t, obs_bias_t, obs_valid_t, obs_done_t;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_idle(input int t);
        e_cs[t] = NOLAYER; e_idx[t] = -1; e_cstart[t] = 0; e_bias[t] = 0;
        e_valid[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_err[t] = model_err;
    endtask

    task automatic set_layer(input int t, input int i);
        e_cs[t] = codes[i]; e_idx[t] = i; e_cstart[t] = 0; e_bias[t] = 0;
        e_valid[t] = 0; e_busy[t] = 1; e_done[t] = 0; e_err[t] = model_err;
    endtask

    // Timeline per layer starting at b: SETUP b..b+1, CONV from b+2 (conv_start) until
    // conv_done at b+2+lat, BIAS at b+3+lat, CAPTURE at b+4+lat, next layer at b+5+lat.
    task automatic build_pass(input int fixed_lat, input bit hold_done, input bit noise, input int noresp);
        int p, b, lat;
        bit finished;
        for (int t = 0; t < MAXT; t++) begin
            d_start[t] = 0; d_abort[t] = 0; d_done[t] = 0; conv_late[t] = 0;
        end
        p = $urandom_range(4, 1);
        for (int t = 0; t < p; t++) set_idle(t);
        d_start[p-1] = 1;
        start_t = p - 1;
        b = p;
        model_err = 0;
        finished = 1;
        for (int i = 0; i < 5; i++) begin
            set_layer(b, i); set_layer(b + 1, i);
            if (i == noresp) begin
                for (int t = b + 2; t <= b + 2 + TMO; t++) set_layer(t, i);
                for (int t = b + 3; t <= b + 2 + TMO; t++) conv_late[t] = 1;
                e_cstart[b+2] = 1;
                model_err = 1;
                b = b + 3 + TMO;
                finished = 0;
                break;
            end
            lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(6, 1);
            if (i == 2) begin c2_t = b + 2; lat2 = lat; end
            for (int t = b + 2; t <= b + 2 + lat; t++) set_layer(t, i);
            for (int t = b + 3; t < b + 2 + lat; t++) conv_late[t] = 1;
            e_cstart[b+2] = 1;
            d_done[b+2+lat] = 1;
            set_layer(b + 3 + lat, i); e_bias[b+3+lat] = 1; bias_t[i] = b + 3 + lat;
            set_layer(b + 4 + lat, i); e_valid[b+4+lat] = 1;
            b = b + 5 + lat;
        end
        if (finished) begin
            set_idle(b); e_busy[b] = 1; e_done[b] = 1;
            b++;
        end
        for (int t = b; t < b + 3; t++) set_idle(t);
        plen = b + 3;
        for (int t = 0; t < plen; t++) begin
            if (hold_done) d_done[t] = 1;
            else if (noise && !conv_late[t] && $urandom_range(2, 0) == 0) d_done[t] = 1;
            if (noise && e_busy[t] && $urandom_range(2, 0) == 0) d_start[t] = 1;
        end
    endtask

    task automatic apply_abort(input int ta);
        d_abort[ta] = 1;
        for (int t = ta + 1; t < ta + 4; t++) begin
            set_idle(t); e_idx[t] = 0; d_start[t] = 0;
        end
        plen = ta + 4;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_cs"},    bus.cs_layer, NOLAYER);
        check_eq({tag, "_idx"},   bus.layer_idx, 0);
        check_eq({tag, "_pulse"}, {bus.conv_start, bus.bias_load, bus.layer_valid, bus.done}, 0);
        check_eq({tag, "_busy"},  bus.busy, 0);
        check_eq({tag, "_err"},   bus.err, 0);
    endtask

    task automatic run_pass(input int rst_at);
        obs_cs_t = -1; obs_bias_t = -1; obs_valid_t = -1; obs_done_t = -1;
        for (int t = 0; t < plen; t++) begin
            bus.start = d_start[t]; bus.abort = d_abort[t]; bus.conv_done = d_done[t];
            @(negedge clk);
            check_eq($sformatf("cs_layer[%0d]", t),    bus.cs_layer,    e_cs[t]);
            if (e_idx[t] >= 0)
                check_eq($sformatf("layer_idx[%0d]", t), bus.layer_idx, e_idx[t]);
            check_eq($sformatf("conv_start[%0d]", t),  bus.conv_start,  e_cstart[t]);
            check_eq($sformatf("bias_load[%0d]", t),   bus.bias_load,   e_bias[t]);
            check_eq($sformatf("layer_valid[%0d]", t), bus.layer_valid, e_valid[t]);
            check_eq($sformatf("busy[%0d]", t),        bus.busy,        e_busy[t]);
            check_eq($sformatf("done[%0d]", t),        bus.done,        e_done[t]);
            check_eq($sformatf("err[%0d]", t),         bus.err,         e_err[t]);
            check_eq($sformatf("pulse_excl[%0d]", t),
                     (32'(bus.conv_start) + 32'(bus.bias_load) + 32'(bus.layer_valid) + 32'(bus.done)) <= 1, 1);
            if (bus.conv_start  && obs_cs_t < 0)    obs_cs_t = t;
            if (bus.bias_load   && obs_bias_t < 0)  obs_bias_t = t;
            if (bus.layer_valid && obs_valid_t < 0) obs_valid_t = t;
            if (bus.done        && obs_done_t < 0)  obs_done_t = t;
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset("rst_mid");
                model_err = 0;
                bus.start = 0; bus.abort = 0; bus.conv_done = 0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.start = 0; bus.abort = 0; bus.conv_done = 0;
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.conv_done = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;

        // Directed timing: latency 5, no noise.
        build_pass(5, 0, 0, -1);
        run_pass(-1);
        check_eq("first_conv_start_ofs", obs_cs_t - start_t, 3);
        check_eq("first_bias_ofs",       obs_bias_t - start_t, 9);
        check_eq("first_valid_ofs",      obs_valid_t - start_t, 10);
        check_eq("done_ofs",             obs_done_t - start_t, 51);

        // conv_done stuck high: entry-cycle done is masked, spurious starts ignored.
        build_pass(1, 1, 1, -1);
        run_pass(-1);
        check_eq("held_done_bias_ofs", obs_bias_t - obs_cs_t, 2);

        for (int k = 0; k < 6; k++) begin
            build_pass(0, 0, 1, -1);
            run_pass(-1);
        end

        // Abort somewhere in layer 2 CONV, then restart.
        build_pass(0, 0, 1, -1);
        apply_abort($urandom_range(c2_t + lat2, c2_t));
        run_pass(-1);
        build_pass(0, 0, 1, -1);
        run_pass(-1);

        // abort and start together in IDLE.
        for (int t = 0; t < MAXT; t++) begin d_start[t] = 0; d_abort[t] = 0; d_done[t] = 0; end
        for (int t = 0; t < 6; t++) set_idle(t);
        d_start[1] = 1; d_abort[1] = 1;
        plen = 6;
        run_pass(-1);

        // Reset in the middle of a BIAS cycle.
        build_pass(0, 0, 1, -1);
        run_pass(bias_t[$urandom_range(4, 0)]);
        @(posedge clk); #1;
        rst_n = 1'b1;
        build_pass(0, 0, 1, -1);
        run_pass(-1);

`ifdef LAYER_SEQ_WATCHDOG_EN
        build_pass(0, 0, 1, $urandom_range(4, 0));
        run_pass(-1);
        check_eq("wd_conv_start_seen", obs_cs_t >= 0, 1);
        build_pass(0, 0, 1, -1);
        run_pass(-1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
